// File: rtl/adc32_arb_pkg.sv
// Shared definitions for the ADC32 adder arbiter: state encoding, data width
// and requester index constants.
package adc32_arb_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/adc32_rr_pick.sv
// Combinational two-way round-robin picker. A lone request always wins; on a
// tie the requester that was not granted last time wins.
module adc32_rr_pick
    import adc32_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic winner
);

    // Pick the winner from the current requests and the previous grant.
    always_comb begin
        // NOTE: every output gets a value before any branch so no latch is inferred.
        valid  = req0 | req1;
        winner = REQ0;
        if (req0 && req1) begin
            winner = ~last_grant;
        end else if (req1) begin
            winner = REQ1;
        end
    end

endmodule

// File: rtl/adc32_arbiter.sv
// Shares one external ADC32 32-bit adder between two requesters with
// round-robin arbitration and a req/ack handshake. Operands are registered
// onto the adder inputs at grant, the sum is sampled after EXEC_CYCLES cycles
// and ack pulses for one cycle with the registered result.
// Optional feature: define ADC32_ARB_OVF_EN to add a registered signed
// overflow output (ovf).
module adc32_arbiter
    import adc32_arb_pkg::*;
#(
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic              sub0,
    input  logic              req1,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    input  logic              sub1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] res,
    output logic              co,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    output logic              add_c0,
    input  logic [DATA_W-1:0] add_s,
    input  logic              add_co
`ifdef ADC32_ARB_OVF_EN
    ,
    output logic              ovf
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              last_grant;
    logic              winner_q;
    logic              pick_valid;
    logic              pick_winner;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic              sel_sub;

    adc32_rr_pick u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // Operands of whichever requester the picker currently favours.
    assign sel_a   = (pick_winner == REQ1) ? a1   : a0;
    assign sel_b   = (pick_winner == REQ1) ? b1   : b0;
    assign sel_sub = (pick_winner == REQ1) ? sub1 : sub0;

    // Grant / execute / respond sequencer with registered adder inputs and results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_grant <= REQ1;
            winner_q   <= REQ0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            res        <= '0;
            co         <= 1'b0;
            add_a      <= '0;
            add_b      <= '0;
            add_c0     <= 1'b0;
`ifdef ADC32_ARB_OVF_EN
            ovf        <= 1'b0;
`endif
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        // Subtraction is a + ~b + 1 on the shared adder.
                        add_a      <= sel_a;
                        add_b      <= sel_sub ? ~sel_b : sel_b;
                        add_c0     <= sel_sub;
                        winner_q   <= pick_winner;
                        last_grant <= pick_winner;
                        cnt        <= '0;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt == CNT_LAST) begin
                        res   <= add_s;
                        co    <= add_co;
`ifdef ADC32_ARB_OVF_EN
                        ovf   <= (add_a[DATA_W-1] == add_b[DATA_W-1]) &&
                                 (add_s[DATA_W-1] != add_a[DATA_W-1]);
`endif
                        ack0  <= (winner_q == REQ0);
                        ack1  <= (winner_q == REQ1);
                        cnt   <= '0;
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc32_arbiter.sv
// Self-checking bench for adc32_arbiter. A transaction-level model predicts,
// from grant time and the arbitration rule, when each ack must appear and what
// result it carries; one compare process checks the DUT every cycle. Directed
// cases pin the model with hand-computed literals, then randomized traffic
// follows. A second instance with EXEC_CYCLES=4 checks the longer latency.
module tb_adc32_arbiter;

    localparam int E = 1;

    logic        clk;
    logic        rst;
    logic        req0, req1, sub0, sub1;
    logic [31:0] a0, b0, a1, b1;
    logic        ack0, ack1, co, add_c0, add_co;
    logic [31:0] res, add_a, add_b, add_s;
`ifdef ADC32_ARB_OVF_EN
    logic        ovf;
    logic        q_ovf;
`endif

    logic        q_req, q_ack0, q_ack1, q_co, q_add_c0, q_add_co;
    logic [31:0] q_a, q_b, q_res, q_add_a, q_add_b, q_add_s;

    // External ADC32 adders seen by each instance.
    assign {add_co, add_s}     = {1'b0, add_a} + {1'b0, add_b} + 33'(add_c0);
    assign {q_add_co, q_add_s} = {1'b0, q_add_a} + {1'b0, q_add_b} + 33'(q_add_c0);

    adc32_arbiter #(.EXEC_CYCLES(1), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .sub0(sub0),
        .req1(req1), .a1(a1), .b1(b1), .sub1(sub1),
        .ack0(ack0), .ack1(ack1), .res(res), .co(co),
        .add_a(add_a), .add_b(add_b), .add_c0(add_c0),
        .add_s(add_s), .add_co(add_co)
`ifdef ADC32_ARB_OVF_EN
        , .ovf(ovf)
`endif
    );

    adc32_arbiter #(.EXEC_CYCLES(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .req0(q_req), .a0(q_a), .b0(q_b), .sub0(1'b0),
        .req1(1'b0), .a1(32'd0), .b1(32'd0), .sub1(1'b0),
        .ack0(q_ack0), .ack1(q_ack1), .res(q_res), .co(q_co),
        .add_a(q_add_a), .add_b(q_add_b), .add_c0(q_add_c0),
        .add_s(q_add_s), .add_co(q_add_co)
`ifdef ADC32_ARB_OVF_EN
        , .ovf(q_ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Arithmetic meaning of one operation, independent of how the adder is driven.
    function automatic void expected_result(input logic [31:0] a, input logic [31:0] b, input bit sub,
                                            output logic [31:0] r, output bit c, output bit v);
        logic [32:0] wide;
        if (sub) begin
            r = a - b;
            c = (a >= b);
            v = (a[31] != b[31]) && (r[31] != a[31]);
        end else begin
            wide = {1'b0, a} + {1'b0, b};
            r = wide[31:0];
            c = wide[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
        end
    endfunction

    // Transaction model: busy window after each grant, ack at grant+E, next grant at grant+E+2.
    int          cyc = 0;
    bit          m_busy = 0;
    int          m_done = 0;
    int          m_idle_at = 0;
    bit          m_last = 1;
    bit          m_win = 0;
    logic [31:0] m_a = '0, m_b = '0;
    bit          m_sub = 0;
    logic [31:0] m_res = '0;
    bit          m_co = 0, m_ovf = 0;
    bit          m_ack0 = 0, m_ack1 = 0;

    // Model update on each rising edge, DUT comparison on the following falling edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_busy = 0; m_last = 1; m_res = '0; m_co = 0; m_ovf = 0;
                m_ack0 = 0; m_ack1 = 0; m_idle_at = cyc + 1;
            end else begin
                m_ack0 = 0;
                m_ack1 = 0;
                if (m_busy && cyc == m_done) begin
                    expected_result(m_a, m_b, m_sub, m_res, m_co, m_ovf);
                    if (m_win) m_ack1 = 1; else m_ack0 = 1;
                    m_busy = 0;
                end else if (!m_busy && cyc >= m_idle_at && (req0 || req1)) begin
                    m_win  = (req0 && req1) ? !m_last : req1;
                    m_last = m_win;
                    m_a    = m_win ? a1 : a0;
                    m_b    = m_win ? b1 : b0;
                    m_sub  = m_win ? sub1 : sub0;
                    m_done = cyc + E;
                    m_idle_at = cyc + E + 2;
                    m_busy = 1;
                end
            end
            @(negedge clk);
            check("cyc_ack0", 32'(ack0), 32'(m_ack0));
            check("cyc_ack1", 32'(ack1), 32'(m_ack1));
            check("cyc_res",  res,       m_res);
            check("cyc_co",   32'(co),   32'(m_co));
`ifdef ADC32_ARB_OVF_EN
            check("cyc_ovf",  32'(ovf),  32'(m_ovf));
`endif
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Issue one request, hold until its ack (bounded), then drop it.
    task automatic do_op(input bit r, input logic [31:0] a, input logic [31:0] b, input bit sub,
                         output int lat, output logic [31:0] b_seen, output bit c0_seen,
                         output bit other_seen);
        if (r) begin req1 = 1; a1 = a; b1 = b; sub1 = sub; end
        else   begin req0 = 1; a0 = a; b0 = b; sub0 = sub; end
        lat = 0; b_seen = '0; c0_seen = 0; other_seen = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) begin b_seen = add_b; c0_seen = add_c0; end
            if (r ? ack0 : ack1) other_seen = 1;
            if (r ? ack1 : ack0) begin lat = i; break; end
        end
        if (r) req1 = 0; else req0 = 0;
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    int          lat;
    logic [31:0] bs;
    bit          cs, oth, both;
    int          k, n_acks;
    int          order[4];
    int          at[4];

    initial begin
        rst = 1; req0 = 0; req1 = 0; sub0 = 0; sub1 = 0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        q_req = 0; q_a = '0; q_b = '0;
        tick(); tick();

        // Reset state.
        check("rst_res",    res,            32'd0);
        check("rst_co",     32'(co),        32'd0);
        check("rst_add_a",  add_a,          32'd0);
        check("rst_add_b",  add_b,          32'd0);
        check("rst_add_c0", 32'(add_c0),    32'd0);
        check("rst_acks",   32'({ack0, ack1}), 32'd0);
        rst = 0;
        tick();

        // Single add with carry ripple through the low half.
        do_op(0, 32'h0000_FFFF, 32'h0000_0001, 0, lat, bs, cs, oth);
        check("add_lat",   32'(lat), 32'd2);
        check("add_res",   res,      32'h0001_0000);
        check("add_co",    32'(co),  32'd0);
        check("add_ack1",  32'(oth), 32'd0);
        tick();

        // Carry-out from requester 1.
        do_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 0, lat, bs, cs, oth);
        check("cry_lat", 32'(lat), 32'd2);
        check("cry_res", res,      32'h0000_0000);
        check("cry_co",  32'(co),  32'd1);
        tick();

        // Subtract with borrow.
        do_op(0, 32'd5, 32'd7, 1, lat, bs, cs, oth);
        check("sub_add_b",  bs,       32'hFFFF_FFF8);
        check("sub_add_c0", 32'(cs),  32'd1);
        check("sub_res",    res,      32'hFFFF_FFFE);
        check("sub_co",     32'(co),  32'd0);
        tick();

`ifdef ADC32_ARB_OVF_EN
        do_op(0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1, lat, bs, cs, oth);
        check("ovf_flag", 32'(ovf), 32'd1);
        check("ovf_res",  res,      32'h8000_0000);
        tick();
`endif

        // Contention from reset: both requesters hold 1+1.
        rst = 1;
        req0 = 1; a0 = 1; b0 = 1; sub0 = 0;
        req1 = 1; a1 = 1; b1 = 1; sub1 = 0;
        tick();
        rst = 0;
        k = 0; both = 0;
        for (int i = 1; i <= 40 && k < 4; i++) begin
            tick();
            if (ack0 && ack1) both = 1;
            if (ack0) begin order[k] = 0; at[k] = i; k++; end
            else if (ack1) begin order[k] = 1; at[k] = i; k++; end
        end
        req0 = 0; req1 = 0;
        check("rr_count", 32'(k), 32'd4);
        if (k == 4) begin
            check("rr_order", 32'({order[0][0], order[1][0], order[2][0], order[3][0]}), 32'b0101);
            check("rr_gap01", 32'(at[1] - at[0]), 32'd3);
            check("rr_gap12", 32'(at[2] - at[1]), 32'd3);
            check("rr_gap23", 32'(at[3] - at[2]), 32'd3);
        end
        check("rr_both", 32'(both), 32'd0);
        check("rr_res",  res,       32'd2);
        tick(); tick();

        // Reset during EXEC drops the operation.
        req0 = 1; a0 = 32'd40; b0 = 32'd2; sub0 = 0;
        tick();
        rst = 1; req0 = 0;
        tick();
        check("rmid_res",  res,                32'd0);
        check("rmid_ack",  32'({ack0, ack1}),  32'd0);
        rst = 0;
        oth = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ack0 || ack1) oth = 1;
        end
        check("rmid_noack", 32'(oth), 32'd0);
        req0 = 1; a0 = 32'd3;   b0 = 32'd4; sub0 = 0;
        req1 = 1; a1 = 32'd100; b1 = 32'd1; sub1 = 0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ack0 || ack1) begin lat = i; break; end
        end
        check("rmid_first0", 32'({ack0, ack1}), 32'b10);
        check("rmid_res0",   res,               32'd7);
        req0 = 0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ack1) begin lat = i; break; end
        end
        check("rmid_lat1", 32'(lat), 32'd3);
        check("rmid_res1", res,      32'd101);
        req1 = 0;
        tick(); tick();

        // Longer execute window on the second instance.
        q_req = 1; q_a = 32'd10000; q_b = 32'd20000;
        lat = 0; oth = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (q_ack1) oth = 1;
            if (q_ack0) begin lat = i; break; end
        end
        q_req = 0;
        check("e4_lat",  32'(lat), 32'd5);
        check("e4_res",  q_res,    32'd30000);
        check("e4_co",   32'(q_co), 32'd0);
        check("e4_ack1", 32'(oth), 32'd0);
        tick();

        // Randomized traffic obeying the requester contract.
        n_acks = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (rst) begin
                rst = 0;
            end else if ($urandom_range(299) == 0) begin
                rst = 1; req0 = 0; req1 = 0;
            end else begin
                if (ack0 || ack1) n_acks++;
                if (req0 && ack0) begin
                    if ($urandom_range(3) == 0) begin a0 = rand_word(); b0 = rand_word(); sub0 = 1'($urandom_range(1)); end
                    else req0 = 0;
                end else if (!req0 && $urandom_range(2) == 0) begin
                    req0 = 1; a0 = rand_word(); b0 = rand_word(); sub0 = 1'($urandom_range(1));
                end
                if (req1 && ack1) begin
                    if ($urandom_range(3) == 0) begin a1 = rand_word(); b1 = rand_word(); sub1 = 1'($urandom_range(1)); end
                    else req1 = 0;
                end else if (!req1 && $urandom_range(2) == 0) begin
                    req1 = 1; a1 = rand_word(); b1 = rand_word(); sub1 = 1'($urandom_range(1));
                end
            end
        end
        req0 = 0; req1 = 0; rst = 0;
        check("rand_progress", 32'(n_acks > 300), 32'd1);
        tick(); tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adc32_arbiter.md
Name: adc32_arbiter

Overview:
- Shares one external ADC32 32-bit adder between two requesters (e.g. PC-increment path and ALU/game-logic path).
- Round-robin arbitration, req/ack handshake, registered operands and result; add or subtract per request.
- Sits between the requesters and the ADC32 instance; it drives ai/bi/C0 and samples s/Co.

Parameters:
- EXEC_CYCLES, 1, cycles the adder inputs are held stable before the sum is sampled (1..15; covers ripple-carry settling).
- CNT_W, 4, width of the EXEC wait counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0  in  1  requester 0 request
- a0  in  32  requester 0 operand A
- b0  in  32  requester 0 operand B
- sub0  in  1  requester 0: 1 = A-B, 0 = A+B
- req1, a1, b1, sub1  in  1/32/32/1  same for requester 1
- ack0  out  1  one-cycle pulse: res/co valid for requester 0
- ack1  out  1  one-cycle pulse: res/co valid for requester 1
- res  out  32  registered result
- co  out  1  registered carry-out (subtract: 1 = no borrow)
- add_a  out  32  to ADC32 ai
- add_b  out  32  to ADC32 bi
- add_c0  out  1  to ADC32 C0
- add_s  in  32  from ADC32 s
- add_co  in  1  from ADC32 Co

Behaviour:
- Reset (async, rst=1): state IDLE; ack0=ack1=0; res=0; co=0; add_a=add_b=0; add_c0=0; wait counter=0; last_grant=1, so requester 0 wins the first tie.
- States: IDLE, EXEC, RESP.
- IDLE: on a clock edge with any req high, pick a winner, register its operands into add_a/add_b/add_c0, then go to EXEC.
  - Add: add_b=b, add_c0=0.
  - Subtract: add_b=~b, add_c0=1.
  - Record the winner and set last_grant to the winner.
  - No req: stay in IDLE, adder inputs hold their previous values.
- Arbitration:
  - Only one req high: that requester wins.
  - Both high: winner = !last_grant.
- EXEC: counter counts 0..EXEC_CYCLES-1. On the edge where the counter reaches EXEC_CYCLES-1, capture res=add_s and co=add_co, assert the winner's ack, go to RESP, clear the counter.
- RESP: ack high for exactly this one cycle, then deassert and return to IDLE.
- Latency: req sampled at edge N → ack high in the cycle after edge N+EXEC_CYCLES. With the default, ack is high two cycles after the request is first seen.
- Throughput: one operation per EXEC_CYCLES+2 cycles.
- Requester contract:
  - Hold req and operands stable until ack.
  - Operands are captured at grant; later changes are ignored.
  - If req is still high in the RESP cycle, it is treated as a new request in IDLE.
- res/co hold their value until the next capture.
- ack0 and ack1 are never high together.
- A non-winning req stays pending, with no ack, until it is served.
- Width rules:
  - All arithmetic is modulo 2^32.
  - Carry-out comes only from add_co; no internal adder.
- Reset mid-operation: the in-flight operation is dropped, no ack is issued, and all outputs return to reset values.

Optional Feature:
- Macro: ADC32_ARB_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit, reset 0), registered with res.
  - ovf = (add_a[31]==add_b[31]) && (add_s[31]!=add_a[31]), i.e. signed overflow of the add or subtract actually performed.
- Undefined: no ovf port and no related logic.

Decomposition:
- Package adc32_arb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2;
  - DATA_W=32;
  - requester index constants REQ0=1'b0, REQ1=1'b1.
- One natural sub-module: adc32_rr_pick, a combinational 2-way round-robin picker with inputs req0, req1, last_grant and outputs valid, winner.
- FSM, operand muxing and result registers stay in the top module.

Test Plan:
- Reset then single add: req0, a0=0x0000FFFF, b0=0x00000001, sub0=0 → ack0 high 2 cycles after the request; res=0x00010000, co=0; ack1 stays 0.
- Carry-out: req1, a1=0xFFFFFFFF, b1=0x00000001 → ack1; res=0x00000000, co=1.
- Subtract: req0, a0=5, b0=7, sub0=1 → add_b=0xFFFFFFF8, add_c0=1; res=0xFFFFFFFE, co=0.
  - With ADC32_ARB_OVF_EN: a0=0x7FFFFFFF, b0=0xFFFFFFFF, sub0=1 → ovf=1.
- Contention: req0 and req1 held high together from reset, both adding 1+1 → ack order 0,1,0,1; acks 3 cycles apart; never simultaneous.
- EXEC_CYCLES=4: single add 10000+20000 → ack high in the cycle after edge N+4; res=30000.
- Reset mid-op: assert rst during EXEC → no ack; res=0, state IDLE; the next request completes normally with requester 0 preferred on a tie.
